// File: rtl/arcade_input_pkg.sv
// Shared types and bit maps for the arcade player-input front end.
// Input nibbles are R/L/D/U from bit0; output nibbles are U/R/D/L from bit0.
package arcade_input_pkg;

    localparam int DIR_RIGHT = 0;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_UP    = 3;

    localparam int OUT_UP    = 0;
    localparam int OUT_RIGHT = 1;
    localparam int OUT_DOWN  = 2;
    localparam int OUT_LEFT  = 3;

    typedef enum logic [2:0] {
        D_NONE,
        D_UP,
        D_DOWN,
        D_LEFT,
        D_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GAP
    } coin_state_t;

    // Highest-priority set direction: UP > DOWN > LEFT > RIGHT.
    function automatic dir_t pick_dir(input logic [3:0] bits);
        dir_t d;
        d = D_NONE;
        if (bits[DIR_UP])         d = D_UP;
        else if (bits[DIR_DOWN])  d = D_DOWN;
        else if (bits[DIR_LEFT])  d = D_LEFT;
        else if (bits[DIR_RIGHT]) d = D_RIGHT;
        return d;
    endfunction

    // True when direction d is currently held in the input-order nibble.
    function automatic logic dir_held(input dir_t d, input logic [3:0] bits);
        logic h;
        h = 1'b0;
        unique case (d)
            D_UP:    h = bits[DIR_UP];
            D_DOWN:  h = bits[DIR_DOWN];
            D_LEFT:  h = bits[DIR_LEFT];
            D_RIGHT: h = bits[DIR_RIGHT];
            default: h = 1'b0;
        endcase
        return h;
    endfunction

    // One-hot active-high output nibble for a single direction.
    function automatic logic [3:0] dir_to_out(input dir_t d);
        logic [3:0] o;
        o = 4'b0000;
        unique case (d)
            D_UP:    o[OUT_UP]    = 1'b1;
            D_DOWN:  o[OUT_DOWN]  = 1'b1;
            D_LEFT:  o[OUT_LEFT]  = 1'b1;
            D_RIGHT: o[OUT_RIGHT] = 1'b1;
            default: o = 4'b0000;
        endcase
        return o;
    endfunction

    // Reorder an input-order nibble into output order, active high.
    function automatic logic [3:0] remap(input logic [3:0] bits);
        logic [3:0] o;
        o = 4'b0000;
        o[OUT_UP]    = bits[DIR_UP];
        o[OUT_RIGHT] = bits[DIR_RIGHT];
        o[OUT_DOWN]  = bits[DIR_DOWN];
        o[OUT_LEFT]  = bits[DIR_LEFT];
        return o;
    endfunction

endpackage

// File: rtl/arcade_input_conditioner_debounce.sv
// Single-bit debouncer: the stable value flips after DB_CYCLES consecutive
// differing ce samples; a trailing register isolates it from downstream logic.
module input_debounce
    import arcade_input_pkg::*;
#(
    parameter int DB_CYCLES = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ce,
    input  logic raw,
    output logic db
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          db_q, db_d;

    // Count disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (ce) begin
            if (raw == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
            end else begin
                cnt_d = CW'(cnt_q + 1'b1);
            end
        end
    end

    assign db_d = stable_q;

    // Debounce state and output register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            db_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            db_q     <= db_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/arcade_input_conditioner.sv
// Player-input front end: debounce, optional 4-way arbitration, coin stretch.
// Define INPUT_4WAY_EN for per-player 4-way joystick exclusivity.
module arcade_input_conditioner
    import arcade_input_pkg::*;
#(
    parameter int PLAYERS   = 2,
    parameter int DB_CYCLES = 8,
    parameter int COIN_HOLD = 3
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic                 vblank,
    input  logic [PLAYERS*4-1:0] joy_in,
    input  logic [PLAYERS-1:0]   start_in,
    input  logic                 coin_in,
    output logic [PLAYERS*4-1:0] ctrl_n,
    output logic [PLAYERS-1:0]   start_n,
    output logic                 coin_n,
    output logic                 coin_busy
);

    localparam int NB  = PLAYERS * 5 + 1;
    localparam int CCW = (COIN_HOLD > 1) ? $clog2(COIN_HOLD) : 1;

    logic [NB-1:0]        raw_all;
    logic [NB-1:0]        db_all;
    logic [PLAYERS*4-1:0] joy_db;
    logic [PLAYERS-1:0]   start_db;
    logic                 coin_db;

    assign raw_all  = {coin_in, start_in, joy_in};
    assign joy_db   = db_all[PLAYERS*4-1:0];
    assign start_db = db_all[PLAYERS*5-1:PLAYERS*4];
    assign coin_db  = db_all[NB-1];

    for (genvar i = 0; i < NB; i++) begin : g_db
        input_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk_sys(clk_sys),
            .reset_n(reset_n),
            .ce     (ce),
            .raw    (raw_all[i]),
            .db     (db_all[i])
        );
    end

    logic [PLAYERS*4-1:0] ctrl_n_q, ctrl_n_d;
    logic [PLAYERS-1:0]   start_n_q, start_n_d;

`ifdef INPUT_4WAY_EN
    logic [PLAYERS*4-1:0] joy_prev_q;

    // Previous debounced directions for rising-edge detection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) joy_prev_q <= '0;
        else          joy_prev_q <= joy_db;
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_arb
        logic [3:0] held;
        logic [3:0] rise;
        dir_t       active_q, active_d;

        assign held = joy_db[p*4 +: 4];
        assign rise = held & ~joy_prev_q[p*4 +: 4];

        // Newest press wins; on release fall back to highest held direction.
        always_comb begin
            active_d = active_q;
            if (|rise) begin
                active_d = pick_dir(rise);
            end else if (!dir_held(active_q, held)) begin
                active_d = pick_dir(held);
            end
        end

        // Per-player arbitration state.
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) active_q <= D_NONE;
            else          active_q <= active_d;
        end

        assign ctrl_n_d[p*4 +: 4] = ~dir_to_out(active_d);
    end
`else
    for (genvar p = 0; p < PLAYERS; p++) begin : g_pass
        assign ctrl_n_d[p*4 +: 4] = ~remap(joy_db[p*4 +: 4]);
    end
`endif

    assign start_n_d = ~start_db;

    logic        vblank_q;
    logic        coin_prev_q;
    logic        vb_rise;
    logic        coin_rise;
    coin_state_t state_q, state_d;
    logic [CCW-1:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        coin_n_q, coin_n_d;
    logic        coin_busy_q, coin_busy_d;

    assign vb_rise   = vblank & ~vblank_q;
    assign coin_rise = coin_db & ~coin_prev_q;

    // Coin stretch FSM: hold coin_n low for COIN_HOLD frames, then a gap frame.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        unique case (state_q)
            ST_IDLE: begin
                if (coin_rise) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (coin_rise) pending_d = 1'b1;
                if (vb_rise) begin
                    if (cnt_q == CCW'(COIN_HOLD - 1)) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = CCW'(cnt_q + 1'b1);
                    end
                end
            end
            ST_GAP: begin
                if (coin_rise) pending_d = 1'b1;
                if (vb_rise) begin
                    if (pending_q || coin_rise) begin
                        state_d   = ST_HOLD;
                        cnt_d     = '0;
                        pending_d = pending_q && coin_rise;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
        endcase
        coin_n_d    = (state_d != ST_HOLD);
        coin_busy_d = (state_d != ST_IDLE) | pending_d;
    end

    // Coin FSM state, edge-detect copies and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q    <= 1'b0;
            coin_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            coin_n_q    <= 1'b1;
            coin_busy_q <= 1'b0;
            ctrl_n_q    <= '1;
            start_n_q   <= '1;
        end else begin
            vblank_q    <= vblank;
            coin_prev_q <= coin_db;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            coin_n_q    <= coin_n_d;
            coin_busy_q <= coin_busy_d;
            ctrl_n_q    <= ctrl_n_d;
            start_n_q   <= start_n_d;
        end
    end

    assign ctrl_n    = ctrl_n_q;
    assign start_n   = start_n_q;
    assign coin_n    = coin_n_q;
    assign coin_busy = coin_busy_q;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Self-checking bench for arcade_input_conditioner (PLAYERS=2, DB_CYCLES=8,
// COIN_HOLD=3); direction cases follow the INPUT_4WAY_EN build setting.
module tb_arcade_input_conditioner;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       vblank;
    logic [7:0] joy_in;
    logic [1:0] start_in;
    logic       coin_in;
    logic [7:0] ctrl_n;
    logic [1:0] start_n;
    logic       coin_n;
    logic       coin_busy;

    int n_checks = 0;
    int n_fails  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    arcade_input_conditioner #(
        .PLAYERS  (2),
        .DB_CYCLES(8),
        .COIN_HOLD(3)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ce       (ce),
        .vblank   (vblank),
        .joy_in   (joy_in),
        .start_in (start_in),
        .coin_in  (coin_in),
        .ctrl_n   (ctrl_n),
        .start_n  (start_n),
        .coin_n   (coin_n),
        .coin_busy(coin_busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic vb_pulse();
        vblank = 1'b1;
        tick(4);
        vblank = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        exp_q.push_back(16'h00FF);
        exp_q.push_back(16'h0003);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n) !== e) begin
            n_fails++; $display("FAIL rst_ctrl_n got %h want %h", ctrl_n, e);
        end
        e = exp_q.pop_front(); n_checks++;
        if (16'(start_n) !== e) begin
            n_fails++; $display("FAIL rst_start_n got %h want %h", start_n, e);
        end
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL rst_coin_n got %h want %h", coin_n, e);
        end
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_busy) !== e) begin
            n_fails++; $display("FAIL rst_busy got %h want %h", coin_busy, e);
        end
        reset_n = 1'b1;
        tick(100);
        exp_q.push_back(16'h00FF);
        exp_q.push_back(16'h0003);
        exp_q.push_back(16'h0001);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n) !== e) begin
            n_fails++; $display("FAIL idle_ctrl_n got %h want %h", ctrl_n, e);
        end
        e = exp_q.pop_front(); n_checks++;
        if (16'(start_n) !== e) begin
            n_fails++; $display("FAIL idle_start_n got %h want %h", start_n, e);
        end
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL idle_coin_n got %h want %h", coin_n, e);
        end
    endtask

    task automatic test_debounce();
        joy_in[3] = 1'b1;
        tick(5);
        joy_in[3] = 1'b0;
        exp_q.push_back(16'h00FF);
        tick(15);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n) !== e) begin
            n_fails++; $display("FAIL glitch got %h want %h", ctrl_n, e);
        end
        joy_in[3] = 1'b1;
        exp_q.push_back(16'h00FF);
        exp_q.push_back(16'h00FE);
        tick(9);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n) !== e) begin
            n_fails++; $display("FAIL hold_9 got %h want %h", ctrl_n, e);
        end
        tick(1);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n) !== e) begin
            n_fails++; $display("FAIL hold_10 got %h want %h", ctrl_n, e);
        end
        tick(2);
        joy_in[3] = 1'b0;
        exp_q.push_back(16'h00FF);
        tick(10);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n) !== e) begin
            n_fails++; $display("FAIL release got %h want %h", ctrl_n, e);
        end
    endtask

    task automatic test_ce_freeze();
        ce = 1'b0;
        joy_in[3] = 1'b1;
        exp_q.push_back(16'h00FF);
        exp_q.push_back(16'h00FE);
        tick(20);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n) !== e) begin
            n_fails++; $display("FAIL ce_frozen got %h want %h", ctrl_n, e);
        end
        ce = 1'b1;
        tick(10);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n) !== e) begin
            n_fails++; $display("FAIL ce_resume got %h want %h", ctrl_n, e);
        end
        joy_in[3] = 1'b0;
        tick(12);
    endtask

    task automatic test_start();
        start_in = 2'b10;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0003);
        tick(10);
        e = exp_q.pop_front(); n_checks++;
        if (16'(start_n) !== e) begin
            n_fails++; $display("FAIL start_p2 got %h want %h", start_n, e);
        end
        start_in = 2'b00;
        tick(10);
        e = exp_q.pop_front(); n_checks++;
        if (16'(start_n) !== e) begin
            n_fails++; $display("FAIL start_rel got %h want %h", start_n, e);
        end
    endtask

`ifdef INPUT_4WAY_EN
    task automatic test_4way();
        joy_in[5] = 1'b1;
        exp_q.push_back(16'h0007);
        exp_q.push_back(16'h000E);
        exp_q.push_back(16'h0007);
        tick(10);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n[7:4]) !== e) begin
            n_fails++; $display("FAIL p2_left got %h want %h", ctrl_n[7:4], e);
        end
        joy_in[7] = 1'b1;
        tick(10);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n[7:4]) !== e) begin
            n_fails++; $display("FAIL p2_up_wins got %h want %h", ctrl_n[7:4], e);
        end
        joy_in[7] = 1'b0;
        tick(10);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n[7:4]) !== e) begin
            n_fails++; $display("FAIL p2_fallback got %h want %h", ctrl_n[7:4], e);
        end
        joy_in[5] = 1'b0;
        tick(12);
        joy_in[0] = 1'b1;
        joy_in[2] = 1'b1;
        exp_q.push_back(16'h000B);
        exp_q.push_back(16'h000D);
        exp_q.push_back(16'h00FF);
        tick(10);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n[3:0]) !== e) begin
            n_fails++; $display("FAIL p1_tie got %h want %h", ctrl_n[3:0], e);
        end
        joy_in[2] = 1'b0;
        tick(10);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n[3:0]) !== e) begin
            n_fails++; $display("FAIL p1_right got %h want %h", ctrl_n[3:0], e);
        end
        joy_in[0] = 1'b0;
        tick(10);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n) !== e) begin
            n_fails++; $display("FAIL dir_clear got %h want %h", ctrl_n, e);
        end
    endtask
`else
    task automatic test_8way();
        joy_in[3] = 1'b1;
        joy_in[0] = 1'b1;
        joy_in[7] = 1'b1;
        joy_in[5] = 1'b1;
        exp_q.push_back(16'h000C);
        exp_q.push_back(16'h0006);
        exp_q.push_back(16'h00FF);
        tick(10);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n[3:0]) !== e) begin
            n_fails++; $display("FAIL p1_up_right got %h want %h", ctrl_n[3:0], e);
        end
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n[7:4]) !== e) begin
            n_fails++; $display("FAIL p2_up_left got %h want %h", ctrl_n[7:4], e);
        end
        joy_in = 8'h00;
        tick(10);
        e = exp_q.pop_front(); n_checks++;
        if (16'(ctrl_n) !== e) begin
            n_fails++; $display("FAIL dir_clear got %h want %h", ctrl_n, e);
        end
    endtask
`endif

    // Checks coin_n and coin_busy against the two oldest queued values.
    task automatic test_coin();
        coin_in = 1'b1;
        tick(10);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
        coin_in = 1'b0;
        tick(10);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL c1_start got %h want %h", coin_n, e);
        end
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_busy) !== e) begin
            n_fails++; $display("FAIL c1_busy got %h want %h", coin_busy, e);
        end
        vb_pulse();
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL c1_f1 got %h want %h", coin_n, e);
        end
        coin_in = 1'b1;
        tick(10);
        coin_in = 1'b0;
        tick(10);
        vb_pulse();
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL c1_f2 got %h want %h", coin_n, e);
        end
        vb_pulse();
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0001);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL c1_f3 got %h want %h", coin_n, e);
        end
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_busy) !== e) begin
            n_fails++; $display("FAIL gap_busy got %h want %h", coin_busy, e);
        end
        vb_pulse();
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL c2_start got %h want %h", coin_n, e);
        end
        vb_pulse();
        vb_pulse();
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL c2_f2 got %h want %h", coin_n, e);
        end
        vb_pulse();
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0001);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL c2_f3 got %h want %h", coin_n, e);
        end
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_busy) !== e) begin
            n_fails++; $display("FAIL c2_gap_busy got %h want %h", coin_busy, e);
        end
        vb_pulse();
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_busy) !== e) begin
            n_fails++; $display("FAIL c_idle_busy got %h want %h", coin_busy, e);
        end
    endtask

    task automatic test_coin_vblank_same_cycle();
        coin_in = 1'b1;
        tick(9);
        vblank = 1'b1;
        tick(1);
        coin_in = 1'b0;
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL sc_start got %h want %h", coin_n, e);
        end
        tick(3);
        vblank = 1'b0;
        tick(12);
        vb_pulse();
        vb_pulse();
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL sc_f2 got %h want %h", coin_n, e);
        end
        vb_pulse();
        exp_q.push_back(16'h0001);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL sc_f3 got %h want %h", coin_n, e);
        end
        vb_pulse();
    endtask

    task automatic test_reset_mid_pulse();
        coin_in = 1'b1;
        tick(10);
        coin_in = 1'b0;
        tick(10);
        coin_in = 1'b1;
        tick(10);
        coin_in = 1'b0;
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL mid_pre got %h want %h", coin_n, e);
        end
        reset_n = 1'b0;
        #2;
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL mid_async got %h want %h", coin_n, e);
        end
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_busy) !== e) begin
            n_fails++; $display("FAIL mid_busy got %h want %h", coin_busy, e);
        end
        tick(3);
        reset_n = 1'b1;
        tick(5);
        vb_pulse();
        vb_pulse();
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_n) !== e) begin
            n_fails++; $display("FAIL post_coin_n got %h want %h", coin_n, e);
        end
        e = exp_q.pop_front(); n_checks++;
        if (16'(coin_busy) !== e) begin
            n_fails++; $display("FAIL post_pending got %h want %h", coin_busy, e);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        ce       = 1'b1;
        vblank   = 1'b0;
        joy_in   = 8'h00;
        start_in = 2'b00;
        coin_in  = 1'b0;
        test_reset();
        test_debounce();
        test_ce_freeze();
        test_start();
`ifdef INPUT_4WAY_EN
        test_4way();
`else
        test_8way();
`endif
        test_coin();
        test_coin_vblank_same_cycle();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/arcade_input_conditioner.md
# arcade_input_conditioner

Parametrised player-input front end between the host/simulation input bundle and the arcade core's active-low input ports. Debounces raw controls, optionally enforces 4-way joystick exclusivity per player, and stretches the coin pulse over a fixed number of frames so the game CPU's vblank-polled coin routine always sees it. It replaces ad-hoc inversion and packing in the top level, and scales to any player count.

## Interface

Parameters:
- PLAYERS, 2, number of joystick/start channels
- DB_CYCLES, 8, consecutive `ce` samples a raw bit must hold before its debounced value changes (≥1)
- COIN_HOLD, 3, vblank rising edges for which `coin_n` stays asserted per accepted coin (≥1)

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  sample enable for debouncing; all other logic runs every `clk_sys`
- vblank  in  1  core vertical blank, active high
- joy_in  in  PLAYERS*4  raw, active high; nibble p = player p, bit0 right, bit1 left, bit2 down, bit3 up
- start_in  in  PLAYERS  raw start buttons, active high
- coin_in  in  1  raw coin, active high
- ctrl_n  out  PLAYERS*4  active low; nibble p: bit0 up, bit1 right, bit2 down, bit3 left
- start_n  out  PLAYERS  debounced start, active low
- coin_n  out  1  stretched coin, active low
- coin_busy  out  1  high while a coin pulse is in progress or pending

## Operation

- Debounce, per raw bit: a counter increments on each `ce` where raw ≠ stable and clears when raw = stable. Reaching DB_CYCLES flips stable and clears the counter. Reset: stable = 0, counter = 0.
- Direction arbitration per player, with INPUT_4WAY_EN:
  - State is `active_dir` ∈ {NONE, UP, DOWN, LEFT, RIGHT}.
  - A debounced rising edge on a direction makes it active, so the newest press wins.
  - Several rising edges in the same cycle are resolved by priority UP > DOWN > LEFT > RIGHT.
  - If the active direction is released, the highest-priority still-held direction becomes active, or NONE if nothing is held.
  - Output is one-hot or all-released.
- Coin FSM, with states IDLE, HOLD and GAP:
  - IDLE → HOLD on a debounced coin rising edge. `coin_n` = 0 and the frame counter is cleared.
  - In HOLD, each vblank rising edge increments the counter. At COIN_HOLD the FSM goes to GAP and `coin_n` = 1.
  - GAP → IDLE on the next vblank rising edge, or → HOLD directly if `pending` is set (then `pending` clears).
  - A coin edge seen in HOLD or GAP sets the 1-deep `pending` flag. Further edges while `pending` is set are dropped.
  - `coin_busy` = (state ≠ IDLE) | pending.
- Start bits: debounced, inverted, registered; no arbitration.
- Reset values: `ctrl_n` all 1, `start_n` all 1, `coin_n` = 1, `coin_busy` = 0, FSM in IDLE, `active_dir` = NONE, `pending` = 0.

## Timing

- Raw change held steady → output change: DB_CYCLES `ce` samples, plus 1 `clk_sys` for the debounce register, plus 1 `clk_sys` for the output register.
- A vblank edge is detected with a 1-cycle delayed copy. `coin_n` deasserts 1 cycle after the COIN_HOLD-th rising edge.
- A coin edge and a vblank edge in the same cycle while IDLE: enter HOLD, and that vblank edge is not counted.
- With `ce` held low, debounce state freezes. Arbitration and the coin FSM keep running.
- Reset asserted mid-pulse: `coin_n` returns to 1 immediately (asynchronous) and `pending` is lost.

## Configuration

- INPUT_4WAY_EN defined: arbitration as above.
- INPUT_4WAY_EN undefined: debounced directions pass straight through (8-way, simultaneous bits allowed) and the arbitration state is not built. Latency is unchanged.

## Structure

- Package `arcade_input_pkg` holds:
  - DIR_RIGHT/LEFT/DOWN/UP input bit indices and OUT_UP/RIGHT/DOWN/LEFT output bit indices
  - `dir_t` enum (NONE, UP, DOWN, LEFT, RIGHT)
  - `coin_state_t` enum (IDLE, HOLD, GAP)
- Sub-module `input_debounce` (single bit, DB_CYCLES parameter) is instantiated by generate for PLAYERS*5+1 bits.

## Test plan

- Reset, then idle for 100 cycles with `ce` = 1 → `ctrl_n` = 8'hFF, `start_n` = 2'b11, `coin_n` = 1.
- P1 up raw pulses for 5 cycles with DB_CYCLES=8 → no output change. P1 up held for 12 cycles → `ctrl_n[0]` = 0 exactly 10 cycles after the hold starts.
- 4-way: hold P2 left, then add P2 up → `ctrl_n[7:4]` = 4'b1110 (up only). Release up → 4'b0111 (left).
- 4-way: P1 right and down rise in the same cycle → down wins, `ctrl_n[3:0]` = 4'b1011.
- Coin pressed, COIN_HOLD=3 → `coin_n` low across exactly 3 vblank rising edges. A second coin during HOLD sets `coin_busy`, and a second full 3-frame pulse follows one GAP frame.
- Build without INPUT_4WAY_EN and hold P1 up+right → `ctrl_n[3:0]` = 4'b1100.
